// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared pixel types, pattern codes and colour-bar palette
package video_pkg;

    typedef logic [23:0] pixel_t;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_GRAD  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_SOLID = 2'd3
    } pattern_e;

    localparam pixel_t BAR_WHITE   = 24'hFFFFFF;
    localparam pixel_t BAR_YELLOW  = 24'hFFFF00;
    localparam pixel_t BAR_CYAN    = 24'h00FFFF;
    localparam pixel_t BAR_GREEN   = 24'h00FF00;
    localparam pixel_t BAR_MAGENTA = 24'hFF00FF;
    localparam pixel_t BAR_RED     = 24'hFF0000;
    localparam pixel_t BAR_BLUE    = 24'h0000FF;
    localparam pixel_t BAR_BLACK   = 24'h000000;

    function automatic pixel_t bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return BAR_WHITE;
            3'd1:    return BAR_YELLOW;
            3'd2:    return BAR_CYAN;
            3'd3:    return BAR_GREEN;
            3'd4:    return BAR_MAGENTA;
            3'd5:    return BAR_RED;
            3'd6:    return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - run/idle FSM, h/v raster counters and unregistered timing decode
module video_timing_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter int HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    output logic [HW-1:0] h,
    output logic [VW-1:0] v,
    output logic          active,
    output logic          hsync,
    output logic          vsync,
    output logic          frame_start,
    output logic          frame_load,
    output logic          line_wrap
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]  state;
    logic        running;
    logic        h_last;
    logic        v_last;
    logic [31:0] hx;
    logic [31:0] vx;

    assign running = (state == ST_RUN);
    assign h_last  = (h == HW'(H_TOTAL - 1));
    assign v_last  = (v == VW'(V_TOTAL - 1));
    assign hx      = 32'(h);
    assign vx      = 32'(v);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            h     <= '0;
            v     <= '0;
        end else if (state == ST_IDLE) begin
            h <= '0;
            v <= '0;
            if (enable) state <= ST_RUN;
        end else if (h_last) begin
            h <= '0;
            if (v_last) begin
                v <= '0;
                // a dropped enable only takes effect once the whole frame is out
                if (!enable) state <= ST_IDLE;
            end else begin
                v <= v + 1'b1;
            end
        end else begin
            h <= h + 1'b1;
        end
    end

    assign active      = running && (hx < H_ACTIVE) && (vx < V_ACTIVE);
    assign hsync       = running && (hx >= H_ACTIVE + H_FP) && (hx < H_ACTIVE + H_FP + H_SYNC);
    assign vsync       = running && (vx >= V_ACTIVE + V_FP) && (vx < V_ACTIVE + V_FP + V_SYNC);
    assign frame_start = running && (h == '0) && (v == '0);

    // high when the next counter state is h = v = 0 of a new frame
    assign frame_load  = enable && ((state == ST_IDLE) || (h_last && v_last));
    assign line_wrap   = !running || h_last;

endmodule

// File: rtl/video_pattern_generator.sv
// rtl/video_pattern_generator.sv - raster source filling the active region with a test pattern
module video_pattern_generator
    import video_pkg::*;
#(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [23:0] solid_color,
    output logic        activeVideo_out,
    output logic [23:0] videoData_out,
    output logic        vsync_out,
    output logic        hsync_out,
    output logic        frame_start_out
);

    localparam int HW    = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int VW    = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam int BAR_W = H_ACTIVE / 8;
    localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          active;
    logic          hsync;
    logic          vsync;
    logic          frame_start;
    logic          frame_load;
    logic          line_wrap;

    pattern_e      pat_q;
    pixel_t        solid_q;
    logic [BW-1:0] bar_pos;
    logic [2:0]    bar_idx;
    logic [7:0]    h_lo;
    logic          h_b5;
    logic          v_b5;
    pixel_t        pix;

    video_timing_gen #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .HW       (HW),       .VW   (VW)
    ) u_timing (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .h           (h),
        .v           (v),
        .active      (active),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_start (frame_start),
        .frame_load  (frame_load),
        .line_wrap   (line_wrap)
    );

    // pattern selection is frozen per frame so a mid-frame change cannot tear
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q   <= PAT_BARS;
            solid_q <= '0;
        end else if (frame_load) begin
            pat_q   <= pattern_e'(pattern_sel);
            solid_q <= solid_color;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || line_wrap) begin
            bar_pos <= '0;
            bar_idx <= '0;
        end else if (bar_pos == BW'(BAR_W - 1)) begin
            bar_pos <= '0;
            bar_idx <= bar_idx + 3'd1;
        end else begin
            bar_pos <= bar_pos + 1'b1;
        end
    end

    assign h_lo = 8'(h);
    assign h_b5 = 1'(32'(h) >> 5);
    assign v_b5 = 1'(32'(v) >> 5);

    always_comb begin
        pix = '0;
        case (pat_q)
            PAT_BARS:  pix = bar_color(bar_idx);
            PAT_GRAD:  pix = {h_lo, h_lo, h_lo};
            PAT_CHECK: pix = (h_b5 ^ v_b5) ? 24'hFFFFFF : 24'h000000;
            PAT_SOLID: pix = solid_q;
            default:   pix = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            activeVideo_out <= 1'b0;
            videoData_out   <= '0;
            hsync_out       <= !SYNC_POL;
            vsync_out       <= !SYNC_POL;
            frame_start_out <= 1'b0;
        end else begin
            activeVideo_out <= active;
            videoData_out   <= active ? pix : 24'h000000;
            hsync_out       <= (hsync == SYNC_POL);
            vsync_out       <= (vsync == SYNC_POL);
            frame_start_out <= frame_start;
        end
    end

endmodule

// File: tb/tb_video_pattern_generator.sv
// tb/tb_video_pattern_generator.sv - randomized bench with a raster-position reference model
module tb_video_pattern_generator;

    localparam int HA [2] = '{16, 64};
    localparam int HFP = 2;
    localparam int HSY = 3;
    localparam int HBP = 3;
    localparam int VA  = 4;
    localparam int VFP = 1;
    localparam int VSY = 2;
    localparam int VBP = 1;
    localparam int VT  = VA + VFP + VSY + VBP;
    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [23:0] solid_color = 24'd0;

    logic        act  [2];
    logic [23:0] data [2];
    logic        vs   [2];
    logic        hs   [2];
    logic        fs   [2];

    always #5 clk = ~clk;

    video_pattern_generator #(
        .H_ACTIVE(16), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .SYNC_POL(1'b1)
    ) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .pattern_sel(pattern_sel),
        .solid_color(solid_color), .activeVideo_out(act[0]), .videoData_out(data[0]),
        .vsync_out(vs[0]), .hsync_out(hs[0]), .frame_start_out(fs[0])
    );

    video_pattern_generator #(
        .H_ACTIVE(64), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .SYNC_POL(1'b1)
    ) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .pattern_sel(pattern_sel),
        .solid_color(solid_color), .activeVideo_out(act[1]), .videoData_out(data[1]),
        .vsync_out(vs[1]), .hsync_out(hs[1]), .frame_start_out(fs[1])
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, want);
    endtask

    // reference model: frame position index, latched pattern and solid colour
    bit          m_run   [2];
    int          m_p     [2];
    int          m_pat   [2];
    logic [23:0] m_solid [2];
    logic [27:0] exp_o   [2];
    bit          m_valid = 1'b0;

    function automatic logic [23:0] model_pix(int h, int v, int ha, int pat, logic [23:0] solid);
        case (pat)
            0:       return BARS[h / (ha / 8)];
            1:       return {3{8'(h % 256)}};
            2:       return (((h / 32) % 2) != ((v / 32) % 2)) ? 24'hFFFFFF : 24'h000000;
            default: return solid;
        endcase
    endfunction

    function automatic logic [27:0] model_out(int k, bit run, int p, int pat, logic [23:0] solid);
        int h, v, ht;
        bit a, hsy, vsy;
        logic [23:0] d;
        if (!run) return 28'd0;
        ht  = HA[k] + HFP + HSY + HBP;
        h   = p % ht;
        v   = p / ht;
        a   = (h < HA[k]) && (v < VA);
        hsy = (h >= HA[k] + HFP) && (h < HA[k] + HFP + HSY);
        vsy = (v >= VA + VFP) && (v < VA + VFP + VSY);
        d   = a ? model_pix(h, v, HA[k], pat, solid) : 24'h000000;
        return {a, d, vsy, hsy, (p == 0)};
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_run[k] = 1'b0; m_p[k] = 0; m_pat[k] = 0; m_solid[k] = '0;
                exp_o[k] = '0;
            end else begin
                exp_o[k] = model_out(k, m_run[k], m_p[k], m_pat[k], m_solid[k]);
                if (!m_run[k]) begin
                    if (enable) begin
                        m_run[k] = 1'b1; m_p[k] = 0;
                        m_pat[k] = int'(pattern_sel); m_solid[k] = solid_color;
                    end
                end else if (m_p[k] == (HA[k] + HFP + HSY + HBP) * VT - 1) begin
                    m_p[k] = 0;
                    if (enable) begin
                        m_pat[k] = int'(pattern_sel); m_solid[k] = solid_color;
                    end else begin
                        m_run[k] = 1'b0;
                    end
                end else begin
                    m_p[k]++;
                end
            end
        end
        m_valid = 1'b1;
    end

    int ncyc = 0;
    int act_cnt, hs_cnt, vs_cnt, fs_cnt, solid_cnt, nz_cnt;
    int fs_q[$];
    int act_q[$];
    int hs_q[$];
    bit prev_act = 1'b0;
    bit prev_hs = 1'b0;
    logic [23:0] line0  [16];
    logic [23:0] line0c [64];
    int pix_i0 = 99;
    int pix_i1 = 99;

    always @(negedge clk) begin
        ncyc++;
        if (m_valid)
            for (int k = 0; k < 2; k++)
                check($sformatf("stream%0d cyc %0d", k, ncyc),
                      32'({act[k], data[k], vs[k], hs[k], fs[k]}), 32'(exp_o[k]));
        act_cnt   += int'(act[0]);
        hs_cnt    += int'(hs[0]);
        vs_cnt    += int'(vs[0]);
        fs_cnt    += int'(fs[0]);
        solid_cnt += int'(data[0] == 24'h123456);
        nz_cnt    += int'(act[0] || (data[0] != 24'd0) || vs[0] || hs[0] || fs[0]);
        if (fs[0]) fs_q.push_back(ncyc);
        if (act[0] && !prev_act) act_q.push_back(ncyc);
        if (hs[0] && !prev_hs) hs_q.push_back(ncyc);
        prev_act = act[0];
        prev_hs  = hs[0];
        if (fs[0]) pix_i0 = 0;
        if (act[0] && pix_i0 < 16) begin line0[pix_i0] = data[0]; pix_i0++; end
        if (fs[1]) pix_i1 = 0;
        if (act[1] && pix_i1 < 64) begin line0c[pix_i1] = data[1]; pix_i1++; end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clr_tally();
        act_cnt = 0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0; solid_cnt = 0; nz_cnt = 0;
    endtask

    task automatic wait_fs(input int budget);
        int n = 0;
        do begin
            step(1);
            n++;
        end while (!fs[0] && n < budget);
        check("wait_fs_bound", 32'(fs[0]), 32'd1);
    endtask

    initial begin
        clr_tally();
        step(4);
        check("reset_idle", 32'({act[0], data[0], vs[0], hs[0], fs[0]}), 32'd0);
        fs_q.delete(); act_q.delete(); hs_q.delete();

        rst = 1'b0; enable = 1'b1;
        step(1);
        check("fs_not_early", 32'(fs[0]), 32'd0);
        step(1);
        check("fs_first", 32'(fs[0]), 32'd1);
        check("first_pixel", 32'(data[0]), 32'h00FFFFFF);
        clr_tally();
        step(192);
        check("act_per_frame", act_cnt, 64);
        check("hs_per_frame", hs_cnt, 24);
        check("vs_per_frame", vs_cnt, 48);
        check("fs_per_frame", fs_cnt, 1);
        check("frame_period", (fs_q.size() >= 2) ? fs_q[1] - fs_q[0] : -1, 192);
        check("line_period", (act_q.size() >= 2) ? act_q[1] - act_q[0] : -1, 24);
        check("hsync_offset", (hs_q.size() >= 1 && act_q.size() >= 1) ? hs_q[0] - act_q[0] : -1, 18);
        for (int i = 0; i < 16; i++)
            check($sformatf("bars_px%0d", i), 32'(line0[i]), 32'(BARS[i / 2]));

        step(40);
        pattern_sel = 2'd3; solid_color = 24'h123456;
        clr_tally();
        step(151);
        check("no_tearing", solid_cnt, 0);
        step(1);
        check("solid_fs", 32'(fs[0]), 32'd1);
        check("solid_first", 32'(data[0]), 32'h00123456);
        clr_tally();
        step(191);
        check("solid_count", solid_cnt, 63);

        pattern_sel = 2'd2;
        step(1200);
        for (int i = 0; i < 64; i++)
            check($sformatf("check_px%0d", i), 32'(line0c[i]), (i >= 32) ? 32'h00FFFFFF : 32'd0);

        repeat (30) begin
            int r;
            step($urandom_range(1, 250));
            r = $urandom_range(0, 9);
            pattern_sel = 2'($urandom);
            solid_color = 24'($urandom);
            if (r == 0) begin
                rst = 1'b1;
                step($urandom_range(1, 3));
                rst = 1'b0;
            end else if (r < 3) begin
                enable = ~enable;
            end
        end

        rst = 1'b1; pattern_sel = 2'd0;
        step(2);
        check("reset_again", 32'({act[0], data[0], vs[0], hs[0], fs[0]}), 32'd0);
        rst = 1'b0; enable = 1'b1;
        wait_fs(50);
        clr_tally();
        step(24);
        enable = 1'b0;
        step(168);
        check("drop_act", act_cnt, 63);
        check("drop_hs", hs_cnt, 24);
        check("drop_vs", vs_cnt, 48);
        check("drop_no_fs", fs_cnt, 0);
        clr_tally();
        step(300);
        check("idle_quiet", nz_cnt, 0);

        enable = 1'b1;
        wait_fs(50);
        step(2);
        rst = 1'b1;
        step(1);
        check("rst_override", 32'({act[0], data[0], vs[0], hs[0], fs[0]}), 32'd0);
        rst = 1'b0;
        step(1);
        check("restart_fs_wait", 32'(fs[0]), 32'd0);
        step(1);
        check("restart_fs", 32'(fs[0]), 32'd1);
        check("restart_act", 32'(act[0]), 32'd1);
        step(5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/video_pattern_generator.md
Name: video_pattern_generator

Overview:
Source end of the pixel stream interface (activeVideo / 24-bit videoData / vsync / hsync) consumed by downstream per-pixel processing stages. It generates raster timing from h/v counters and fills the active region with a selectable test pattern. It drives inverter/filter stages on the bench and on hardware when no camera or HDMI input is present.

Parameters:
H_ACTIVE, 1280, active pixels per line; must be divisible by 8
H_FP, 110, horizontal front porch (pixels)
H_SYNC, 40, hsync width (pixels)
H_BP, 220, horizontal back porch (pixels)
V_ACTIVE, 720, active lines per frame
V_FP, 5, vertical front porch (lines)
V_SYNC, 5, vsync width (lines)
V_BP, 20, vertical back porch (lines)
SYNC_POL, 1, 1 = syncs active-high, 0 = active-low

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous active-high reset
enable  in  1  run request
pattern_sel  in  2  0 = colour bars, 1 = gradient, 2 = checkerboard, 3 = solid
solid_color  in  24  RGB for pattern 3: [23:16] R, [15:8] G, [7:0] B
activeVideo_out  out  1  pixel valid
videoData_out  out  24  pixel RGB
vsync_out  out  1  vertical sync
hsync_out  out  1  horizontal sync
frame_start_out  out  1  one-cycle pulse on first pixel of frame

Behaviour:
- One clock (clk); reset synchronous, active-high (rst).
- H_TOTAL = sum of the four H parameters. V_TOTAL = sum of the four V parameters. Counter widths are $clog2(total).
- FSM states:
  - IDLE: counters h = v = 0.
  - RUN: h increments every cycle. At h = H_TOTAL-1, h wraps to 0 and v increments. At v = V_TOTAL-1, v wraps to 0.
- Transitions:
  - IDLE -> RUN when enable = 1; first counted cycle is h = 0, v = 0.
  - RUN -> IDLE only at end of frame (h = H_TOTAL-1 and v = V_TOTAL-1) with enable = 0. If enable drops mid-frame, the frame completes.
- Line order: active, front porch, sync, back porch. Frame order is the same.
  - hsync asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vsync asserted for whole lines V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC.
  - Assertion is at SYNC_POL level; syncs are generated in blanking lines too.
- active = RUN and h < H_ACTIVE and v < V_ACTIVE.
- Latency: all outputs registered, 1 cycle after the counter state they describe.
- Reset / IDLE outputs:
  - activeVideo_out = 0, videoData_out = 0, frame_start_out = 0.
  - hsync_out and vsync_out at inactive level (0 when SYNC_POL = 1).
  - rst overrides everything in any state: FSM -> IDLE, counters cleared, registered pattern_sel/solid_color cleared to 0.
- pattern_sel and solid_color are registered only when entering RUN and at each frame wrap. Mid-frame changes take effect next frame (no tearing).
- videoData_out = 0 whenever not active.
- Pattern 0, colour bars: 8 bars of BAR_W = H_ACTIVE/8. Bar index comes from a bar counter, not a divider: cleared at h = 0, incremented when the within-bar count reaches BAR_W-1. Colours in order:
  - FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
- Pattern 1, gradient: R = G = B = h[7:0]; wraps every 256 pixels.
- Pattern 2, checkerboard: (h[5] ^ v[5]) ? FFFFFF : 000000 (32x32 squares).
- Pattern 3, solid: the registered solid_color.
- frame_start_out = 1 on exactly the output cycle that carries h = 0, v = 0 in RUN.

Decomposition:
- Package video_pkg:
  - pixel_t (logic [23:0]).
  - pattern_e enum (PAT_BARS, PAT_GRAD, PAT_CHECK, PAT_SOLID).
  - The 8 bar colour constants.
  - Shared by other stream stages.
- Sub-module video_timing_gen:
  - Contains the FSM, h/v counters and unregistered sync/active/frame-start decode.
  - Exposes h and v.
- Top level: pattern logic plus the output register stage.

Test Plan:
All scenarios use small parameters: H 16/2/3/3 (H_TOTAL = 24), V 4/1/2/1 (V_TOTAL = 8), SYNC_POL = 1.
- Reset then enable = 1 at cycle 0 -> first frame_start_out pulse on the cycle after RUN entry. That frame shows 4 lines of 16 consecutive activeVideo_out cycles, and line period = 24 cycles.
- Syncs -> hsync_out high 3 cycles starting 18 cycles after each line's first active pixel. vsync_out high for exactly 48 cycles (lines 5-6); frame period 192 cycles.
- pattern_sel = 0 -> each line's data is pairs FFFFFF×2, FFFF00×2, ..., 000000×2. pattern_sel = 2 at H_ACTIVE = 64 -> pixels 32-63 of line 0 are FFFFFF.
- pattern_sel changed 0 -> 3 (solid_color = 123456) mid-frame -> current frame stays bars; next frame is all 123456.
- enable dropped at line 1 -> frame completes with all 192 cycles of timing, then outputs idle (all 0) and no further frame_start_out.
- rst asserted mid-line during active video -> next cycle all outputs 0. After rst release with enable = 1, a new frame starts from h = 0, v = 0 with a frame_start_out pulse.
